// File: rtl/iram_access_ctrl.sv
// Monitor access sequencer for the shared 1R1W instruction RAM: drains the fetch
// pipeline while the CPU runs, performs one read or write, then releases the pipeline.
module iram_access_ctrl #(
  parameter int IADR_W    = 12,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_run,
  input  logic              mon_req,
  input  logic              mon_we,
  input  logic [IADR_W-1:0] mon_adr,
  input  logic [31:0]       mon_wdata,
  output logic              mon_busy,
  output logic              mon_ack,
  output logic [31:0]       mon_rdata,
  output logic              i_read_sel,
  output logic [IADR_W-1:0] i_ram_radr,
  output logic [IADR_W-1:0] i_ram_wadr,
  output logic [31:0]       i_ram_wdata,
  output logic              i_ram_wen,
  input  logic [31:0]       i_ram_rdata,
  output logic              stall,
  output logic              stall_1shot,
  output logic              stall_dly
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RDWAIT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              we_reg;
  logic              run_reg;
  logic [IADR_W-1:0] adr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              stall_dly_reg;

  logic accept;
  assign accept = (state_reg == ST_IDLE) && mon_req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mon_req) begin
          if (cpu_run) begin
            state_next = ST_DRAIN;
            cnt_next   = DRAIN_LOAD;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == 4'd0) state_next = ST_ACCESS;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_ACCESS: state_next = we_reg ? ST_DONE : ST_RDWAIT;
      ST_RDWAIT: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request and the CPU run state are frozen at acceptance; later changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      run_reg   <= 1'b0;
      adr_reg   <= '0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      we_reg    <= mon_we;
      run_reg   <= cpu_run;
      adr_reg   <= mon_adr;
      wdata_reg <= mon_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= 32'd0;
    end else if (state_reg == ST_RDWAIT) begin
      rdata_reg <= i_ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_dly_reg <= 1'b0;
    else        stall_dly_reg <= stall;
  end

  assign mon_busy    = (state_reg != ST_IDLE);
  assign mon_ack     = (state_reg == ST_DONE);
  assign mon_rdata   = rdata_reg;
  // Read port is handed back during DONE so fetch can re-address before the stall lifts.
  assign i_read_sel  = (state_reg == ST_ACCESS) || (state_reg == ST_RDWAIT);
  assign i_ram_radr  = adr_reg;
  assign i_ram_wadr  = adr_reg;
  assign i_ram_wdata = wdata_reg;
  assign i_ram_wen   = (state_reg == ST_ACCESS) && we_reg;
  assign stall       = run_reg && (state_reg != ST_IDLE);
  assign stall_dly   = stall_dly_reg;
  assign stall_1shot = stall && !stall_dly_reg;

endmodule
